golomb_rice_decode: RTL and testbench

Bit-serial Golomb-Rice decoder for the ProRes entropy path. It consumes the codeword format produced by the encoder: q zero bits, a terminating 1, k remainder bits MSB-first, then one sign bit when the symbol is an AC level. It reconstructs the magnitude, the sign and the codeword length. It sits between the bitstream reader and the run/level reconstruction stage, with a valid/ready handshake on both sides.

---
 rtl/golomb_rice_decode.sv | 149 ++++++++++++++
 tb/tb_golomb_rice_decode.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/golomb_rice_decode.sv
// Bit-serial Golomb-Rice decoder that takes one stream bit per cycle and returns magnitude, sign, length and error.
// The result appears the cycle after the last bit; while it waits for out_ready, bit_ready stays low.
module golomb_rice_decode #(
  parameter int MAX_Q = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  k,
  input  logic        is_ac_level,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic [31:0] val,
  output logic        is_minus,
  output logic [31:0] codeword_length,
  output logic        error,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [2:0] {S_IDLE, S_PREFIX, S_SUFFIX, S_SIGN, S_DONE} state_t;

  localparam logic [31:0] MAXQ = 32'(MAX_Q);

  state_t      r_state;
  logic [2:0]  r_k;
  logic [2:0]  r_cnt;
  logic        r_ac;
  logic [31:0] r_q;
  logic [6:0]  r_rem;
  logic [31:0] r_val;
  logic [31:0] r_len;
  logic        r_minus;
  logic        r_err;
  logic        r_out_valid;

  logic        w_xfer;
  logic        w_idle;
  logic [2:0]  w_k;
  logic        w_ac;
  logic [31:0] w_q;
  logic [31:0] w_base;
  logic [31:0] w_len;
  logic [6:0]  w_rem_sh;
  state_t      w_after_one;

  assign bit_ready = (r_state != S_DONE) && !reset;
  assign w_xfer    = bit_valid && bit_ready;
  assign w_idle    = (r_state == S_IDLE);

  // In IDLE the codeword parameters come straight from the ports, afterwards from the latched copies.
  assign w_k         = w_idle ? k : r_k;
  assign w_ac        = w_idle ? is_ac_level : r_ac;
  assign w_q         = w_idle ? 32'd0 : r_q;
  assign w_rem_sh    = {r_rem[5:0], bit_in};
  assign w_base      = w_q << w_k;
  assign w_len       = w_q + 32'd1 + 32'(w_k) + 32'(w_ac);
  assign w_after_one = (w_k != 3'd0) ? S_SUFFIX : (w_ac ? S_SIGN : S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_k         <= 3'd0;
      r_ac        <= 1'b0;
      r_q         <= 32'd0;
      r_rem       <= 7'd0;
      r_cnt       <= 3'd0;
      r_val       <= 32'd0;
      r_minus     <= 1'b0;
      r_len       <= 32'd0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_PREFIX: if (w_xfer) begin
          if (w_idle) begin
            r_k   <= k;
            r_ac  <= is_ac_level;
            r_rem <= 7'd0;
            r_cnt <= 3'd0;
          end
          if (!bit_in) begin
            if (w_idle) begin
              r_q     <= 32'd1;
              r_state <= S_PREFIX;
            end else if (r_q == MAXQ) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_err       <= 1'b1;
              r_val       <= 32'd0;
              r_minus     <= 1'b0;
              r_len       <= MAXQ + 32'd1;
            end else begin
              r_q <= r_q + 32'd1;
            end
          end else begin
            if (w_idle) r_q <= 32'd0;
            r_state <= w_after_one;
            if (w_after_one == S_DONE) begin
              r_out_valid <= 1'b1;
              r_val       <= w_base;
              r_minus     <= 1'b0;
              r_len       <= w_len;
              r_err       <= 1'b0;
            end
          end
        end
        S_SUFFIX: if (w_xfer) begin
          r_rem <= w_rem_sh;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == r_k - 3'd1) begin
            if (r_ac) begin
              r_state <= S_SIGN;
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_val       <= w_base | {25'd0, w_rem_sh};
              r_minus     <= 1'b0;
              r_len       <= w_len;
              r_err       <= 1'b0;
            end
          end
        end
        S_SIGN: if (w_xfer) begin
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
          r_val       <= w_base | {25'd0, r_rem};
          r_minus     <= bit_in;
          r_len       <= w_len;
          r_err       <= 1'b0;
        end
        S_DONE: if (out_ready) begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_err       <= 1'b0;
          r_minus     <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign val             = r_val;
  assign is_minus        = r_minus;
  assign codeword_length = r_len;
  assign error           = r_err;
  assign out_valid       = r_out_valid;

endmodule

// File: tb/tb_golomb_rice_decode.sv
// Directed bench for golomb_rice_decode: vector table plus back-to-back, backpressure and reset sequences.
module tb_golomb_rice_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  k;
  logic        is_ac_level;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic [31:0] val;
  logic        is_minus;
  logic [31:0] codeword_length;
  logic        error;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  golomb_rice_decode #(.MAX_Q(31)) dut (
    .clk(clk), .reset(reset), .k(k), .is_ac_level(is_ac_level),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .val(val), .is_minus(is_minus), .codeword_length(codeword_length),
    .error(error), .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic [2:0]  k;
    logic        ac;
    string       bits;
    logic [31:0] val;
    logic        minus;
    logic [31:0] len;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] val;
    logic        minus;
    logic [31:0] len;
    logic        err;
  } res_t;

  int   checks = 0;
  int   failures = 0;
  res_t exp_q[$];
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Every accepted result is compared against the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    res_t e;
    #2;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got val=%0d len=%0d, expected no result", val, codeword_length);
      end else begin
        e = exp_q.pop_front();
        chk("result_val", val, e.val);
        chk1("result_is_minus", is_minus, e.minus);
        chk("result_length", codeword_length, e.len);
        chk1("result_error", error, e.err);
      end
    end
  end

  task automatic push_exp(input logic [31:0] v, input logic m, input logic [31:0] l, input logic e);
    res_t r;
    r.val = v; r.minus = m; r.len = l; r.err = e;
    exp_q.push_back(r);
  endtask

  task automatic send_bit(input logic b, input logic [2:0] kk, input logic ac,
                          input int gaps, input logic last, output int stalls);
    int n;
    repeat (gaps) begin
      @(negedge clk);
      bit_valid   = 1'b0;
      bit_in      = 1'($urandom_range(0, 1));
      k           = 3'($urandom_range(0, 7));
      is_ac_level = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bit_valid   = 1'b1;
    bit_in      = b;
    k           = kk;
    is_ac_level = ac;
    n = 0;
    while (!bit_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bit_ready) begin
      checks++;
      failures++;
      $display("FAIL bit_ready_timeout: got bit_ready=0 for %0d cycles, expected 1", n);
    end
    if (last) chk1("out_valid_before_last_bit", out_valid, 1'b0);
    stalls = n;
    @(posedge clk);
  endtask

  // Only the first bit carries the real k/is_ac_level; later bits drive junk to prove it is ignored.
  task automatic send_cw(input logic [2:0] kk, input logic ac, input string bits,
                         input int maxgap, output int first_stalls);
    int st;
    int g;
    logic [2:0] k_i;
    logic ac_i;
    first_stalls = 0;
    for (int i = 0; i < bits.len(); i++) begin
      g    = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      k_i  = (i == 0) ? kk : 3'($urandom_range(0, 7));
      ac_i = (i == 0) ? ac : 1'($urandom_range(0, 1));
      send_bit(bits[i] == "1", k_i, ac_i, g, i == bits.len() - 1, st);
      if (i == 0) first_stalls = st;
    end
    #1;
    chk1("out_valid_after_last_bit", out_valid, 1'b1);
    bit_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pending_results", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    string z32;
    int st;

    z32 = "";
    for (int i = 0; i < 32; i++) z32 = {z32, "0"};

    vecs[0] = '{3'd0, 1'b0, "001",       32'd2,   1'b0, 32'd3, 1'b0};
    vecs[1] = '{3'd2, 1'b1, "01101",     32'd6,   1'b1, 32'd5, 1'b0};
    vecs[2] = '{3'd7, 1'b0, "11111111",  32'd127, 1'b0, 32'd8, 1'b0};
    vecs[3] = '{3'd0, 1'b1, "10",        32'd0,   1'b0, 32'd2, 1'b0};
    vecs[4] = '{3'd1, 1'b1, "000101",    32'd6,   1'b1, 32'd6, 1'b0};
    vecs[5] = '{3'd7, 1'b1, "100000001", 32'd0,   1'b1, 32'd9, 1'b0};
    vecs[6] = '{3'd0, 1'b0, "",          32'd31,  1'b0, 32'd32, 1'b0};
    vecs[6].bits = {z32.substr(0, 30), "1"};
    vecs[7] = '{3'd5, 1'b1, "",          32'd0,   1'b0, 32'd32, 1'b1};
    vecs[7].bits = z32;
    vecs[8] = '{3'd0, 1'b0, "1",         32'd0,   1'b0, 32'd1, 1'b0};
    vecs[9] = '{3'd3, 1'b0, "01101",     32'd13,  1'b0, 32'd5, 1'b0};

    reset = 1'b1; k = 3'd0; is_ac_level = 1'b0; bit_in = 1'b0;
    bit_valid = 1'b0; out_ready = 1'b1;

    @(negedge clk);
    chk("reset_val", val, 32'd0);
    chk("reset_length", codeword_length, 32'd0);
    chk1("reset_is_minus", is_minus, 1'b0);
    chk1("reset_error", error, 1'b0);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_bit_ready", bit_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk1("bit_ready_after_reset", bit_ready, 1'b1);

    for (int i = 0; i < 10; i++) begin
      push_exp(vecs[i].val, vecs[i].minus, vecs[i].len, vecs[i].err);
      send_cw(vecs[i].k, vecs[i].ac, vecs[i].bits, (i % 2 == 1) ? 2 : 0, st);
    end
    wait_drain();

    // Back-to-back codewords: exactly one DONE cycle in which no bit is taken.
    push_exp(32'd127, 1'b0, 32'd8, 1'b0);
    push_exp(32'd0, 1'b0, 32'd2, 1'b0);
    send_cw(3'd7, 1'b0, "11111111", 0, st);
    send_cw(3'd0, 1'b1, "10", 0, st);
    chk("dead_cycle_stalls", 32'(st), 32'd1);
    wait_drain();

    // Backpressure with the next codeword's first bit already offered.
    @(negedge clk);
    out_ready = 1'b0;
    push_exp(32'd6, 1'b1, 32'd5, 1'b0);
    send_cw(3'd2, 1'b1, "01101", 0, st);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bit_valid = 1'b1; bit_in = 1'b0; k = 3'd0; is_ac_level = 1'b0;
      #1;
      chk1("bp_bit_ready", bit_ready, 1'b0);
      chk1("bp_out_valid", out_valid, 1'b1);
      chk("bp_val", val, 32'd6);
      chk1("bp_is_minus", is_minus, 1'b1);
      chk("bp_length", codeword_length, 32'd5);
      chk1("bp_error", error, 1'b0);
    end
    out_ready = 1'b1;
    push_exp(32'd2, 1'b0, 32'd3, 1'b0);
    send_cw(3'd0, 1'b0, "001", 0, st);
    wait_drain();

    // Reset in the middle of the remainder of a k=3 codeword.
    push_exp(32'd13, 1'b0, 32'd5, 1'b0);
    send_cw(3'd3, 1'b0, "01101", 1, st);
    wait_drain();
    send_bit(1'b1, 3'd3, 1'b0, 1, 1'b0, st);
    send_bit(1'b0, 3'd3, 1'b0, 2, 1'b0, st);
    @(negedge clk);
    bit_valid = 1'b1; bit_in = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_val", val, 32'd0);
    chk("midreset_length", codeword_length, 32'd0);
    chk1("midreset_is_minus", is_minus, 1'b0);
    chk1("midreset_error", error, 1'b0);
    chk1("midreset_out_valid", out_valid, 1'b0);
    chk1("midreset_bit_ready", bit_ready, 1'b0);
    bit_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_exp(32'd13, 1'b0, 32'd5, 1'b0);
    send_cw(3'd3, 1'b0, "01101", 2, st);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
